cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; reset_n input 1, asynchronous active-low reset.
REQ-002 The block SHALL have these ports:
- req_valid input 5: result-ready strobe per requester (0-3 = res1-res4 ALUs, 4 = resbr).
- req_tag input 5x3: ROB tag of each result.
- req_data input 5x32: result value of each requester.
- req_ready output 5: per-requester accept; a transfer occurs when req_valid & req_ready at a rising edge.
- flush input 1: ROB flush in progress; squash all pending broadcasts.
- cdb_valid output 1: broadcast valid this cycle.
- cdb_tag output 3: broadcast ROB tag.
- cdb_data output 32: broadcast value.
- cdb_src output 3: index of the winning requester, 0-4.
- pending output 5: holding-register occupancy vector.

Function
REQ-003 The block SHALL hold one holding register per requester (valid bit, tag, data), loaded on each accepted transfer.
REQ-004 req_ready[i] SHALL be (!hold_v[i] | grant[i]) & !flush, derived only from registered state and flush, with no combinational path from req_valid.
REQ-005 grant SHALL be one-hot or zero, computed each cycle from hold_v and rr_ptr: the first set hold_v searching from index rr_ptr upward, modulo 5.
REQ-006 On a grant to index i, the next edge SHALL:
- register cdb_valid=1, cdb_tag, cdb_data and cdb_src=i from hold[i];
- clear hold_v[i], unless requester i transfers in the same cycle, in which case hold[i] reloads with the new result;
- set rr_ptr=(i+1) mod 5, wrapping 4->0.
REQ-007 With no grant, the next edge SHALL set cdb_valid=0, leave rr_ptr unchanged and hold cdb_tag, cdb_data and cdb_src.
REQ-008 Latency SHALL be:
- minimum: a transfer at edge k into an idle arbiter yields cdb_valid=1 in the cycle after edge k+1;
- worst case under contention: 5 edges after capture.
REQ-009 Throughput SHALL be one broadcast per cycle while any hold_v is set, and each requester SHALL sustain one result per cycle while it wins.
REQ-010 When flush=1 at an edge, the block SHALL:
- clear all hold_v and cdb_valid;
- discard any simultaneous transfer;
- leave rr_ptr unchanged;
- take priority over every other event.
REQ-011 pending SHALL equal hold_v.
REQ-012 rr_ptr SHALL never hold values 5-7, and any such value SHALL be treated as 0.

Reset
REQ-013 While reset_n=0, the block SHALL asynchronously hold hold_v=0, rr_ptr=0, cdb_valid=0, cdb_tag=0, cdb_data=0 and cdb_src=0, which makes req_ready=5'b11111 and pending=0.
REQ-014 Reset asserted mid-broadcast SHALL drop all pending results without emitting them.
REQ-015 After reset_n rises, the first accepted transfer SHALL be captured at the first rising edge.

Configuration
REQ-016 With CDB_BR_PRIORITY_EN defined, the block SHALL:
- grant index 4 (resbr) whenever hold_v[4]=1, regardless of rr_ptr;
- leave rr_ptr unchanged on a resbr grant;
- apply REQ-005 among indices 0-3 otherwise.
REQ-017 Without CDB_BR_PRIORITY_EN, all five requesters SHALL be arbitrated purely round-robin per REQ-005.

Verification
REQ-018 The bench SHALL cover single request: reset, req_valid[2]=1 with tag=3, data=0xDEADBEEF for one cycle -> cdb_valid=1, tag=3, data=0xDEADBEEF, src=2 two edges later, then rr_ptr=3.
REQ-019 The bench SHALL cover full contention: all five requesters load tags 0-4 in the same cycle with rr_ptr=0 -> five consecutive broadcasts with src 0,1,2,3,4, then cdb_valid=0; with CDB_BR_PRIORITY_EN the order is 4,0,1,2,3.
REQ-020 The bench SHALL cover back-to-back from one requester: req_valid[0] held high with data 1,2,3 and no other requests -> req_ready[0] stays 1 and the CDB shows 1,2,3 on consecutive cycles.
REQ-021 The bench SHALL cover wrap-around: rr_ptr=4, hold_v=5'b10001 -> src=4 first, then src=0, then rr_ptr=1.
REQ-022 The bench SHALL cover flush: pending=5'b01110 and a new req_valid[0] in the same cycle as flush=1 -> next cycle pending=0, cdb_valid=0, and the transfer from requester 0 is lost.
REQ-023 The bench SHALL cover asynchronous reset: reset_n driven low between edges while cdb_valid=1 -> cdb_valid=0 and pending=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester holding registers, round-robin grant, one broadcast per cycle.
// Build option CDB_BR_PRIORITY_EN: branch unit (index 4) always wins and does not advance rr_ptr.
module cdb_arbiter (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [4:0]      req_valid,
  input  logic [4:0][2:0] req_tag,
  input  logic [4:0][31:0] req_data,
  output logic [4:0]      req_ready,
  input  logic            flush,
  output logic            cdb_valid,
  output logic [2:0]      cdb_tag,
  output logic [31:0]     cdb_data,
  output logic [2:0]      cdb_src,
  output logic [4:0]      pending
);

  logic [4:0]       hold_v_q, hold_v_d;
  logic [4:0][2:0]  hold_tag_q;
  logic [4:0][31:0] hold_data_q;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [2:0]       rr_start;
  logic             cdb_valid_q;
  logic [2:0]       cdb_tag_q, cdb_src_q;
  logic [31:0]      cdb_data_q;
  logic [4:0]       grant, accept;
  logic [2:0]       grant_idx;
  logic             grant_any;

  // Out-of-range pointer values are folded back to 0.
  assign rr_start = (rr_ptr_q > 3'd4) ? 3'd0 : rr_ptr_q;

  always_comb begin
    logic [3:0] cand;
    grant_any = 1'b0;
    grant_idx = 3'd0;
    cand      = 4'd0;
`ifdef CDB_BR_PRIORITY_EN
    if (hold_v_q[4]) begin
      grant_any = 1'b1;
      grant_idx = 3'd4;
    end else begin
      for (int k = 0; k < 4; k++) begin
        cand = ((rr_start == 3'd4) ? 4'd0 : {1'b0, rr_start}) + 4'(k);
        if (cand >= 4'd4) cand = cand - 4'd4;
        if (!grant_any && hold_v_q[cand[2:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[2:0];
        end
      end
    end
`else
    for (int k = 0; k < 5; k++) begin
      cand = {1'b0, rr_start} + 4'(k);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!grant_any && hold_v_q[cand[2:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[2:0];
      end
    end
`endif
  end

  assign grant     = grant_any ? (5'b00001 << grant_idx) : 5'b00000;
  assign req_ready = (~hold_v_q | grant) & {5{~flush}};
  assign accept    = req_valid & req_ready;
  assign hold_v_d  = flush ? 5'b00000 : ((hold_v_q & ~grant) | accept);

  always_comb begin
    rr_ptr_d = rr_start;
    if (!flush && grant_any) begin
`ifdef CDB_BR_PRIORITY_EN
      if (grant_idx != 3'd4) rr_ptr_d = grant_idx + 3'd1;
`else
      rr_ptr_d = (grant_idx == 3'd4) ? 3'd0 : grant_idx + 3'd1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_v_q    <= 5'b00000;
      rr_ptr_q    <= 3'd0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= 3'd0;
      cdb_data_q  <= 32'd0;
      cdb_src_q   <= 3'd0;
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
      if (!flush && grant_any) begin
        cdb_valid_q <= 1'b1;
        cdb_tag_q   <= hold_tag_q[grant_idx];
        cdb_data_q  <= hold_data_q[grant_idx];
        cdb_src_q   <= grant_idx;
      end else begin
        cdb_valid_q <= 1'b0;
      end
    end
  end

  // Payload is only meaningful while its valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (accept[i]) begin
        hold_tag_q[i]  <= req_tag[i];
        hold_data_q[i] <= req_data[i];
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign pending   = hold_v_q;

endmodule
